// File: rtl/hpi_pkg.sv
// ============================================================================
// Module   : hpi_pkg
// Brief    : Shared encodings for the CY7C67200 HPI bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpi_pkg;

   localparam logic [2:0] OP_REG_RD   = 3'd0;
   localparam logic [2:0] OP_REG_WR   = 3'd1;
   localparam logic [2:0] OP_MEM_RD   = 3'd2;
   localparam logic [2:0] OP_MEM_WR   = 3'd3;
   localparam logic [2:0] OP_CHIP_RST = 3'd4;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDR    = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SETUP      = 3'd1,
      ST_STROBE     = 3'd2,
      ST_HOLD       = 3'd3,
      ST_RECOV      = 3'd4,
      ST_RST_ASSERT = 3'd5,
      ST_RST_WAIT   = 3'd6
   } hpi_state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hpi_bus_sequencer_if.sv
// ============================================================================
// Module   : hpi_bus_sequencer_if
// Brief    : Request/response handshake plus HPI pad-side signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hpi_bus_sequencer_if;

   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [1:0]  req_reg;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;

   logic [1:0]  hpi_addr;
   logic        hpi_cs_n;
   logic        hpi_r_n;
   logic        hpi_w_n;
   logic        hpi_reset_n;
   logic [15:0] hpi_data_out;
   logic        hpi_data_oe;
   logic [15:0] hpi_data_in;

   modport master (
      output req_valid, req_op, req_reg, req_addr, req_wdata, hpi_data_in,
      input  req_ready, rsp_valid, rsp_rdata, busy,
      input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
      input  hpi_data_out, hpi_data_oe
   );

   modport slave (
      input  req_valid, req_op, req_reg, req_addr, req_wdata, hpi_data_in,
      output req_ready, rsp_valid, rsp_rdata, busy,
      output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
      output hpi_data_out, hpi_data_oe
   );

endinterface

`default_nettype wire

// File: rtl/hpi_phase_counter.sv
// ============================================================================
// Module   : hpi_phase_counter
// Brief    : Loadable down-counter; done is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpi_phase_counter #(
   parameter int WIDTH = 3
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   output logic                  o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (r_count != '0)
         r_count <= r_count - 1'b1;
   end

   assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/hpi_bus_sequencer.sv
// ============================================================================
// Module   : hpi_bus_sequencer
// Brief    : Generates timed HPI cs/r/w/addr/data cycles and chip reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpi_bus_sequencer
   import hpi_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 1,
   parameter int RECOV_CYC  = 2,
   parameter int RST_CYC    = 50000
) (
   input wire logic           clk,
   input wire logic           reset,
   hpi_bus_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(max_of(max_of(max_of(SETUP_CYC, STROBE_CYC),
                                               max_of(HOLD_CYC, RECOV_CYC)), RST_CYC)) + 1;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

   hpi_state_e       r_state;
   hpi_state_e       w_state_next;
   logic             w_ready;
   logic             w_accept;
   logic             w_done;
   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_val;
   logic             w_last_recov;

   logic             r_mem;
   logic             r_mem_wr;
   logic             r_phase;
   logic             r_write;
   logic [15:0]      r_wdata;
   logic [1:0]       r_bus_addr;
   logic [15:0]      r_bus_data;
   logic [15:0]      r_sample;
   logic             r_rsp_valid;
   logic [15:0]      r_rsp_rdata;

   assign w_ready      = (r_state == ST_IDLE) && !reset;
   assign w_accept     = bus.req_valid && w_ready;
   assign w_last_recov = (r_state == ST_RECOV) && w_done && (!r_mem || r_phase);

   hpi_phase_counter #(
      .WIDTH (CNT_W)
   ) u_phase_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .o_done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Ops 5-7 are accepted but leave the FSM in IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (bus.req_op == OP_CHIP_RST)
                  w_state_next = ST_RST_ASSERT;
               else if (bus.req_op <= OP_MEM_WR)
                  w_state_next = ST_SETUP;
            end
         end
         ST_SETUP:      if (w_done) w_state_next = ST_STROBE;
         ST_STROBE:     if (w_done) w_state_next = ST_HOLD;
         ST_HOLD:       if (w_done) w_state_next = ST_RECOV;
         ST_RECOV:      if (w_done) w_state_next = (r_mem && !r_phase) ? ST_SETUP : ST_IDLE;
         ST_RST_ASSERT: if (w_done) w_state_next = ST_RST_WAIT;
         ST_RST_WAIT:   if (w_done) w_state_next = ST_IDLE;
         default:       w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_load = (w_state_next != r_state);
      w_cnt_val  = '0;
      case (w_state_next)
         ST_SETUP:      w_cnt_val = SETUP_LD;
         ST_STROBE:     w_cnt_val = STROBE_LD;
         ST_HOLD:       w_cnt_val = HOLD_LD;
         ST_RECOV:      w_cnt_val = RECOV_LD;
         ST_RST_ASSERT: w_cnt_val = RST_LD;
         ST_RST_WAIT:   w_cnt_val = RST_LD;
         default:       w_cnt_val = '0;
      endcase
   end

   always_comb begin
      bus.req_ready    = w_ready;
      bus.busy         = (r_state != ST_IDLE) && !reset;
      bus.hpi_cs_n     = 1'b1;
      bus.hpi_r_n      = 1'b1;
      bus.hpi_w_n      = 1'b1;
      bus.hpi_reset_n  = 1'b1;
      bus.hpi_data_oe  = 1'b0;
      bus.hpi_addr     = r_bus_addr;
      bus.hpi_data_out = r_bus_data;
      bus.rsp_valid    = r_rsp_valid;
      bus.rsp_rdata    = r_rsp_rdata;
      case (r_state)
         ST_SETUP, ST_HOLD: begin
            bus.hpi_cs_n    = 1'b0;
            bus.hpi_data_oe = r_write;
         end
         ST_STROBE: begin
            bus.hpi_cs_n    = 1'b0;
            bus.hpi_data_oe = r_write;
            bus.hpi_w_n     = !r_write;
            bus.hpi_r_n     = r_write;
         end
         ST_RST_ASSERT: bus.hpi_reset_n = 1'b0;
         default: ;
      endcase
   end

   // Bus address/data are set on entry to SETUP so they are stable for the whole cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem       <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_phase     <= 1'b0;
         r_write     <= 1'b0;
         r_wdata     <= '0;
         r_bus_addr  <= '0;
         r_bus_data  <= '0;
         r_sample    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_accept && (bus.req_op <= OP_MEM_WR)) begin
            r_phase  <= 1'b0;
            r_wdata  <= bus.req_wdata;
            r_mem_wr <= (bus.req_op == OP_MEM_WR);
            if ((bus.req_op == OP_MEM_RD) || (bus.req_op == OP_MEM_WR)) begin
               r_mem      <= 1'b1;
               r_write    <= 1'b1;
               r_bus_addr <= HPI_ADDR;
               r_bus_data <= bus.req_addr;
            end else begin
               r_mem      <= 1'b0;
               r_write    <= (bus.req_op == OP_REG_WR);
               r_bus_addr <= bus.req_reg;
               r_bus_data <= (bus.req_op == OP_REG_WR) ? bus.req_wdata : 16'h0000;
            end
         end
         if ((r_state == ST_RECOV) && w_done && r_mem && !r_phase) begin
            r_phase    <= 1'b1;
            r_write    <= r_mem_wr;
            r_bus_addr <= HPI_DATA;
            r_bus_data <= r_mem_wr ? r_wdata : 16'h0000;
         end
         if ((r_state == ST_STROBE) && w_done && !r_write)
            r_sample <= bus.hpi_data_in;
         if (w_last_recov && !r_write) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_sample;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hpi_bus_sequencer.sv
// ============================================================================
// Module   : tb_hpi_bus_sequencer
// Brief    : Scoreboard bench with an op-level reference model and a pin-level chip model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpi_bus_sequencer;
   import hpi_pkg::*;

   localparam int SETUP_CYC  = 2;
   localparam int STROBE_CYC = 4;
   localparam int HOLD_CYC   = 1;
   localparam int RECOV_CYC  = 2;
   localparam int RST_CYC    = 8;
   localparam int B          = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOV_CYC;

   typedef struct {
      logic [1:0]  addr;
      bit          write;
      logic [15:0] data;
   } bus_t;

   typedef struct {
      logic [15:0] data;
      int unsigned cyc;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   bus_t bus_q[$];
   rsp_t rsp_q[$];

   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] ref_ptr = 16'h0;
   logic [15:0] ref_mbx = 16'h0;
   logic [15:0] chip_mem [logic [15:0]];
   logic [15:0] chip_ptr = 16'h0;
   logic [15:0] chip_mbx = 16'h0;
   logic [15:0] status_val = 16'h1234;

   hpi_bus_sequencer_if bus ();

   hpi_bus_sequencer #(
      .SETUP_CYC  (SETUP_CYC),
      .STROBE_CYC (STROBE_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .RECOV_CYC  (RECOV_CYC),
      .RST_CYC    (RST_CYC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, got, req, cyc);
      end
   endtask

   // ---------------- op-level reference model ----------------
   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic push_bus(input logic [1:0] a, input bit w, input logic [15:0] d);
      bus_t e;
      e.addr = a; e.write = w; e.data = d;
      bus_q.push_back(e);
   endtask

   task automatic push_rsp(input logic [15:0] d, input int unsigned c);
      rsp_t e;
      e.data = d; e.cyc = c;
      rsp_q.push_back(e);
   endtask

   task automatic model(input logic [2:0] op, input logic [1:0] rg, input logic [15:0] a,
                        input logic [15:0] wd, input int unsigned k);
      logic [15:0] v;
      case (op)
         OP_REG_RD: begin
            case (rg)
               HPI_DATA:    v = ref_rd(ref_ptr);
               HPI_MAILBOX: v = ref_mbx;
               HPI_ADDR:    v = ref_ptr;
               default:     v = status_val;
            endcase
            push_bus(rg, 1'b0, 16'h0);
            push_rsp(v, k + B + 1);
         end
         OP_REG_WR: begin
            push_bus(rg, 1'b1, wd);
            if (rg == HPI_DATA) ref_mem[ref_ptr] = wd;
            else if (rg == HPI_MAILBOX) ref_mbx = wd;
            else if (rg == HPI_ADDR) ref_ptr = wd;
         end
         OP_MEM_RD: begin
            push_bus(HPI_ADDR, 1'b1, a);
            push_bus(HPI_DATA, 1'b0, 16'h0);
            ref_ptr = a;
            push_rsp(ref_rd(a), k + 2 * B + 1);
         end
         OP_MEM_WR: begin
            push_bus(HPI_ADDR, 1'b1, a);
            push_bus(HPI_DATA, 1'b1, wd);
            ref_ptr = a;
            ref_mem[a] = wd;
         end
         default: ;
      endcase
   endtask

   // ---------------- pin-level chip model ----------------
   function automatic logic [15:0] chip_read(input logic [1:0] rg);
      case (rg)
         HPI_DATA:    return chip_mem.exists(chip_ptr) ? chip_mem[chip_ptr] : init_val(chip_ptr);
         HPI_MAILBOX: return chip_mbx;
         HPI_ADDR:    return chip_ptr;
         default:     return status_val;
      endcase
   endfunction

   logic prev_w_n = 1'b1;
   always @(negedge clk) begin
      if (!reset && !bus.hpi_w_n && prev_w_n) begin
         case (bus.hpi_addr)
            HPI_DATA:    chip_mem[chip_ptr] = bus.hpi_data_out;
            HPI_MAILBOX: chip_mbx = bus.hpi_data_out;
            HPI_ADDR:    chip_ptr = bus.hpi_data_out;
            HPI_STATUS:  ;
            default:     ;
         endcase
      end
      prev_w_n = reset ? 1'b1 : bus.hpi_w_n;
      bus.hpi_data_in = !bus.hpi_r_n ? chip_read(bus.hpi_addr) : 16'($urandom);
   end

   // ---------------- monitor ----------------
   bit          in_cs = 0, have_prev = 0, inv_bad = 0, unstable = 0;
   bit          saw_w = 0, saw_r = 0, first_oe = 0;
   int          cs_len = 0, st_off = -1, st_len = 0, gap = 0;
   logic [1:0]  first_addr = 2'b0;
   logic [15:0] first_data = 16'h0;

   always @(negedge clk) begin
      if (reset) begin
         in_cs = 0; have_prev = 0; gap = 0;
         bus_q.delete();
         rsp_q.delete();
      end else begin
         if (!bus.hpi_r_n && !bus.hpi_w_n) inv_bad = 1;
         if ((!bus.hpi_r_n || !bus.hpi_w_n) && bus.hpi_cs_n) inv_bad = 1;
         if (bus.hpi_data_oe && (!bus.hpi_r_n || bus.hpi_cs_n)) inv_bad = 1;
         if (!bus.hpi_cs_n) begin
            if (!in_cs) begin
               in_cs = 1; cs_len = 0; st_off = -1; st_len = 0; saw_w = 0; saw_r = 0; unstable = 0;
               first_addr = bus.hpi_addr; first_oe = bus.hpi_data_oe; first_data = bus.hpi_data_out;
               if (have_prev) begin
                  checks++;
                  if (gap < RECOV_CYC) begin
                     errors++;
                     $display("FAIL recov_gap: got=%0d required>=%0d", gap, RECOV_CYC);
                  end
               end
            end
            if (bus.hpi_addr != first_addr || bus.hpi_data_oe != first_oe ||
                (first_oe && bus.hpi_data_out != first_data)) unstable = 1;
            if (!bus.hpi_r_n || !bus.hpi_w_n) begin
               if (st_len == 0) st_off = cs_len;
               st_len++;
               if (!bus.hpi_w_n) saw_w = 1;
               if (!bus.hpi_r_n) saw_r = 1;
            end
            cs_len++;
         end else begin
            if (in_cs) begin
               in_cs = 0; have_prev = 1; gap = 0;
               if (bus_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL bus_unexpected: got addr=%0d w=%0b required none", first_addr, saw_w);
               end else begin
                  bus_t e;
                  e = bus_q.pop_front();
                  check("bus_timing",
                        {8'(cs_len), 8'(st_off), 8'(st_len), unstable, inv_bad},
                        {8'(SETUP_CYC + STROBE_CYC + HOLD_CYC), 8'(SETUP_CYC), 8'(STROBE_CYC), 1'b0, 1'b0});
                  check("bus_content",
                        {first_addr, saw_w, saw_r, first_oe, (first_oe ? first_data : 16'h0)},
                        {e.addr, e.write, !e.write, e.write, (e.write ? e.data : 16'h0)});
               end
            end
            gap++;
         end
         if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_unexpected: got data=%0h required no rsp", bus.rsp_rdata);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               check("rsp_data", 64'(bus.rsp_rdata), 64'(r.data));
               check("rsp_cycle", 64'(cyc), 64'(r.cyc));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [2:0] op, input logic [1:0] rg, input logic [15:0] a,
                        input logic [15:0] wd, output int unsigned acc);
      int n = 0;
      acc = 0;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_reg = rg;
      bus.req_addr = a; bus.req_wdata = wd;
      @(negedge clk);
      while (!bus.req_ready) begin
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got ready=0 required=1");
            bus.req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      acc = cyc;
      model(op, rg, a, wd, cyc);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_op = 3'($urandom); bus.req_reg = 2'($urandom);
      bus.req_addr = 16'($urandom); bus.req_wdata = 16'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(bus.req_ready && bus_q.size() == 0 && rsp_q.size() == 0)) begin
         n++;
         if (n > 300) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got pending bus=%0d rsp=%0d required 0", bus_q.size(), rsp_q.size());
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned acc, acc2;
      int lo_rdy, lo_rst, cs_seen, busy_bad;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_reg = 2'd0;
      bus.req_addr = 16'h0; bus.req_wdata = 16'h0; bus.hpi_data_in = 16'h0;
      ref_mem[16'h1000]  = 16'hCAFE;
      chip_mem[16'h1000] = 16'hCAFE;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {bus.hpi_cs_n, bus.hpi_r_n, bus.hpi_w_n, bus.hpi_reset_n, bus.hpi_data_oe,
             bus.hpi_data_out, bus.hpi_addr, bus.rsp_valid, bus.rsp_rdata, bus.busy, bus.req_ready},
            {4'b1111, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0});
      @(posedge clk); #1;
      reset = 1'b0;

      issue(OP_REG_WR, HPI_MAILBOX, 16'h0, 16'hBEEF, acc);
      wait_idle();
      issue(OP_REG_RD, HPI_STATUS, 16'h0, 16'h0, acc);
      wait_idle();
      issue(OP_MEM_RD, 2'd0, 16'h1000, 16'h0, acc);
      wait_idle();
      issue(OP_REG_RD, HPI_MAILBOX, 16'h0, 16'h0, acc);
      wait_idle();

      issue(OP_MEM_WR, 2'd0, 16'h0400, 16'h5555, acc);
      issue(OP_REG_RD, HPI_DATA, 16'h0, 16'h0, acc2);
      check("b2b_accept_cycle", 64'(acc2), 64'(acc + 2 * B + 1));
      wait_idle();

      issue(OP_CHIP_RST, 2'd0, 16'h0, 16'h0, acc);
      lo_rdy = 0; lo_rst = 0; cs_seen = 0; busy_bad = 0;
      for (int i = 0; i < 100 && !bus.req_ready; i++) begin
         lo_rdy++;
         if (!bus.hpi_reset_n) lo_rst++;
         if (!bus.hpi_cs_n) cs_seen++;
         if (bus.busy != 1'b1) busy_bad++;
         @(posedge clk); #1;
      end
      check("chiprst_ready_low", 64'(lo_rdy), 64'(2 * RST_CYC));
      check("chiprst_reset_low", 64'(lo_rst), 64'(RST_CYC));
      check("chiprst_cs_quiet", 64'(cs_seen), 64'(0));
      check("chiprst_busy", 64'(busy_bad), 64'(0));
      wait_idle();

      issue(OP_REG_RD, HPI_STATUS, 16'h0, 16'h0, acc);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("midop_reset_outputs",
            {bus.hpi_cs_n, bus.hpi_r_n, bus.hpi_w_n, bus.hpi_reset_n, bus.hpi_data_oe, bus.rsp_valid},
            {4'b1111, 1'b0, 1'b0});
      reset = 1'b0;
      #1;
      check("midop_ready_after", 64'(bus.req_ready), 64'(1));
      repeat (15) @(posedge clk);
      #1;

      for (int i = 0; i < 60; i++) begin
         int unsigned r;
         logic [2:0]  op;
         r = $urandom_range(0, 99);
         if (r < 25)      op = OP_REG_RD;
         else if (r < 45) op = OP_REG_WR;
         else if (r < 65) op = OP_MEM_RD;
         else if (r < 85) op = OP_MEM_WR;
         else if (r < 90) op = OP_CHIP_RST;
         else             op = 3'(5 + $urandom_range(0, 2));
         issue(op, 2'($urandom), 16'h0400 + 16'($urandom_range(0, 15)), 16'($urandom), acc);
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      wait_idle();
      repeat (5) @(posedge clk);
      check("queues_drained", {32'(bus_q.size()), 32'(rsp_q.size())}, 64'(0));
      check("invariants", 64'(inv_bad), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
